// File: rtl/rv32_branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve signals of rv32_branch_predict_unit.
// Stats ports exist only when BRANCH_STATS_EN is defined.
interface rv32_branch_predict_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] fetch_pc_in;
  logic            predict_taken_out;
  logic            valid_in;
  logic            flush_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] imm_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] rs2_in;
  logic [4:0]      opcode_6_to_2_in;
  logic [2:0]      funct3_in;
  logic            predicted_taken_in;
  logic            resolve_valid_out;
  logic            branch_taken_out;
  logic [XLEN-1:0] redirect_pc_out;
  logic            mispredict_out;
  logic            illegal_out;
`ifdef BRANCH_STATS_EN
  logic [31:0]     branch_count_out;
  logic [31:0]     mispredict_count_out;
`endif

  modport slave (
    input  fetch_pc_in, valid_in, flush_in, pc_in, imm_in, rs1_in, rs2_in,
           opcode_6_to_2_in, funct3_in, predicted_taken_in,
`ifdef BRANCH_STATS_EN
    output branch_count_out, mispredict_count_out,
`endif
    output predict_taken_out, resolve_valid_out, branch_taken_out,
           redirect_pc_out, mispredict_out, illegal_out
  );

  modport master (
    output fetch_pc_in, valid_in, flush_in, pc_in, imm_in, rs1_in, rs2_in,
           opcode_6_to_2_in, funct3_in, predicted_taken_in,
`ifdef BRANCH_STATS_EN
    input  branch_count_out, mispredict_count_out,
`endif
    input  predict_taken_out, resolve_valid_out, branch_taken_out,
           redirect_pc_out, mispredict_out, illegal_out
  );
endinterface

// File: rtl/rv32_branch_predict_unit.sv
// Bimodal branch predictor with registered branch/jump resolution.
// Optional feature macro: BRANCH_STATS_EN (branch and mispredict counters).
module rv32_branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input logic                          clk_in,
  input logic                          rst_in,
  rv32_branch_predict_unit_if.slave    bus
);
  localparam int unsigned IDXW      = $clog2(BHT_DEPTH);
  localparam logic [4:0]  OP_BRANCH = 5'b11000;
  localparam logic [4:0]  OP_JAL    = 5'b11011;
  localparam logic [4:0]  OP_JALR   = 5'b11001;

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IDXW-1:0] fidx_c, uidx_c;
  logic            is_branch_c, is_jal_c, is_jalr_c, accept_c, illegal_c;
  logic            eq_c, slt_c, ult_c, cond_c, taken_c, mispredict_c, upd_c;
  logic [XLEN-1:0] sum_pc_c, sum_rs_c, fall_c, target_c;
  logic [1:0]      cur_ctr_c, ctr_d;
  logic            unused_fetch_c;

  logic            resolve_valid_q, branch_taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // Fetch lookup reads the stored counter, so a same-edge update is not visible
  assign fidx_c                = bus.fetch_pc_in[IDXW+1:2];
  assign bus.predict_taken_out = bht_q[fidx_c][1];
  assign unused_fetch_c        = ^{bus.fetch_pc_in[XLEN-1:IDXW+2], bus.fetch_pc_in[1:0]};

  assign is_branch_c = (bus.opcode_6_to_2_in == OP_BRANCH);
  assign is_jal_c    = (bus.opcode_6_to_2_in == OP_JAL);
  assign is_jalr_c   = (bus.opcode_6_to_2_in == OP_JALR);
  assign accept_c    = bus.valid_in & ~bus.flush_in & (is_branch_c | is_jal_c | is_jalr_c);
  assign illegal_c   = is_branch_c & (bus.funct3_in[2:1] == 2'b01);

  assign eq_c  = (bus.rs1_in == bus.rs2_in);
  assign slt_c = ($signed(bus.rs1_in) < $signed(bus.rs2_in));
  assign ult_c = (bus.rs1_in < bus.rs2_in);

  always_comb begin
    cond_c = 1'b0;
    case (bus.funct3_in)
      3'b000:  cond_c = eq_c;
      3'b001:  cond_c = ~eq_c;
      3'b100:  cond_c = slt_c;
      3'b101:  cond_c = ~slt_c;
      3'b110:  cond_c = ult_c;
      3'b111:  cond_c = ~ult_c;
      default: cond_c = 1'b0;
    endcase
  end

  // Jumps are unconditionally taken; illegal branch encodings resolve not-taken
  assign taken_c       = is_branch_c ? (cond_c & ~illegal_c) : 1'b1;
  assign mispredict_c  = taken_c ^ bus.predicted_taken_in;
  assign sum_pc_c      = bus.pc_in + bus.imm_in;
  assign sum_rs_c      = bus.rs1_in + bus.imm_in;
  assign fall_c        = bus.pc_in + XLEN'(4);
  assign target_c      = is_jalr_c ? {sum_rs_c[XLEN-1:1], 1'b0} : sum_pc_c;
  assign redirect_pc_d = taken_c ? target_c : fall_c;

  assign uidx_c    = bus.pc_in[IDXW+1:2];
  assign upd_c     = accept_c & is_branch_c & ~illegal_c;
  assign cur_ctr_c = bht_q[uidx_c];

  always_comb begin
    ctr_d = cur_ctr_c;
    if (taken_c) begin
      if (cur_ctr_c != 2'b11) ctr_d = cur_ctr_c + 2'd1;
    end else begin
      if (cur_ctr_c != 2'b00) ctr_d = cur_ctr_c - 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[IDXW'(i)] <= CTR_INIT;
      resolve_valid_q <= 1'b0;
      branch_taken_q  <= 1'b0;
      mispredict_q    <= 1'b0;
      illegal_q       <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      resolve_valid_q <= accept_c;
      if (accept_c) begin
        branch_taken_q <= taken_c;
        mispredict_q   <= mispredict_c;
        illegal_q      <= illegal_c;
        redirect_pc_q  <= redirect_pc_d;
      end
      if (upd_c) bht_q[uidx_c] <= ctr_d;
    end
  end

  assign bus.resolve_valid_out = resolve_valid_q;
  assign bus.branch_taken_out  = branch_taken_q;
  assign bus.mispredict_out    = mispredict_q;
  assign bus.illegal_out       = illegal_q;
  assign bus.redirect_pc_out   = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (upd_c)                   branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (accept_c & mispredict_c) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign bus.branch_count_out     = branch_cnt_q;
  assign bus.mispredict_count_out = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_rv32_branch_predict_unit.sv
// Directed bench for rv32_branch_predict_unit with a behavioural reference model.
module tb_rv32_branch_predict_unit;
  localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  rv32_branch_predict_unit_if #(.XLEN(32)) bus ();

  rv32_branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Reference state: counter values as plain integers, expected registered outputs
  int          m_bht [64];
  logic        m_rv, m_taken, m_misp, m_ill;
  logic [31:0] m_redir;
  logic [31:0] m_bcnt, m_mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  idx;
    bit  legal, tk;
    longint s1, s2, u1, u2;
    logic [4:0] op;
    op = bus.opcode_6_to_2_in;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      {m_rv, m_taken, m_misp, m_ill} = 4'b0;
      m_redir = 32'h0;
      m_bcnt = 32'h0;
      m_mcnt = 32'h0;
    end else if (bus.valid_in && !bus.flush_in && (op == BR || op == JAL || op == JALR)) begin
      s1 = longint'($signed(bus.rs1_in));
      s2 = longint'($signed(bus.rs2_in));
      u1 = longint'({32'h0, bus.rs1_in});
      u2 = longint'({32'h0, bus.rs2_in});
      legal = 1'b1;
      if (op != BR) tk = 1'b1;
      else case (bus.funct3_in)
        3'd0: tk = (u1 == u2);
        3'd1: tk = (u1 != u2);
        3'd4: tk = (s1 < s2);
        3'd5: tk = !(s1 < s2);
        3'd6: tk = (u1 < u2);
        3'd7: tk = !(u1 < u2);
        default: begin tk = 1'b0; legal = 1'b0; end
      endcase
      m_rv    = 1'b1;
      m_taken = tk;
      m_ill   = !legal;
      m_misp  = (tk != bus.predicted_taken_in);
      if (!tk)              m_redir = 32'((longint'(bus.pc_in) + 4) % 64'h1_0000_0000);
      else if (op == JALR)  m_redir = 32'((longint'(bus.rs1_in) + longint'(bus.imm_in)) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
      else                  m_redir = 32'((longint'(bus.pc_in) + longint'(bus.imm_in)) % 64'h1_0000_0000);
      if (m_misp) m_mcnt = m_mcnt + 32'd1;
      if (op == BR && legal) begin
        idx = int'(bus.pc_in / 4) % 64;
        m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                        : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
        m_bcnt = m_bcnt + 32'd1;
      end
    end else begin
      m_rv = 1'b0;
    end
  end

  // Registered outputs just after each edge, prediction mid-cycle after inputs settle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        chk("resolve_valid", 32'(bus.resolve_valid_out), 32'(m_rv));
        chk("branch_taken",  32'(bus.branch_taken_out),  32'(m_taken));
        chk("redirect_pc",   bus.redirect_pc_out,        m_redir);
        chk("mispredict",    32'(bus.mispredict_out),    32'(m_misp));
        chk("illegal",       32'(bus.illegal_out),       32'(m_ill));
`ifdef BRANCH_STATS_EN
        chk("branch_count",     bus.branch_count_out,     m_bcnt);
        chk("mispredict_count", bus.mispredict_count_out, m_mcnt);
`endif
      end
      @(negedge clk);
      #1;
      if (started)
        chk("predict_taken", 32'(bus.predict_taken_out),
            32'(m_bht[int'(bus.fetch_pc_in / 4) % 64] >= 2));
    end
  end

  // Drive one cycle of inputs at the falling edge; return the mid-cycle prediction
  task automatic issue(input bit v, input bit f, input logic [4:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input bit pred, input logic [31:0] fpc, output logic pt);
    @(negedge clk);
    bus.valid_in           = v;
    bus.flush_in           = f;
    bus.opcode_6_to_2_in   = op;
    bus.funct3_in          = f3;
    bus.pc_in              = pc;
    bus.imm_in             = imm;
    bus.rs1_in             = r1;
    bus.rs2_in             = r2;
    bus.predicted_taken_in = pred;
    bus.fetch_pc_in        = fpc;
    #1 pt = bus.predict_taken_out;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] fpc, output logic pt);
    issue(1'b0, 1'b0, 5'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, fpc, pt);
  endtask

  initial begin
    logic pt;
    bus.valid_in = 1'b0; bus.flush_in = 1'b0; bus.opcode_6_to_2_in = 5'b0;
    bus.funct3_in = 3'b0; bus.pc_in = 32'h0; bus.imm_in = 32'h0; bus.rs1_in = 32'h0;
    bus.rs2_in = 32'h0; bus.predicted_taken_in = 1'b0; bus.fetch_pc_in = 32'h100;
    started = 1'b1;

    // Taken BEQ presented during reset must be discarded
    rst = 1'b1;
    issue(1'b1, 1'b0, BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h100, pt);
    issue(1'b1, 1'b0, BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h100, pt);
    @(negedge clk);
    rst = 1'b0;
    bus.valid_in = 1'b0;

    idle(32'h100, pt);
    chk("lit_reset_predict", 32'(pt), 32'd0);
    chk("lit_reset_resolve", 32'(bus.resolve_valid_out), 32'd0);
    chk("lit_reset_redirect", bus.redirect_pc_out, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("lit_reset_bcnt", bus.branch_count_out, 32'h0);
    chk("lit_reset_mcnt", bus.mispredict_count_out, 32'h0);
`endif

    // BEQ taken; lookup in the same cycle still sees the old counter
    issue(1'b1, 1'b0, BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h100, pt);
    chk("lit_beq_samecycle_predict", 32'(pt), 32'd0);
    chk("lit_beq_taken", 32'(bus.branch_taken_out), 32'd1);
    chk("lit_beq_redirect", bus.redirect_pc_out, 32'h120);
    chk("lit_beq_mispredict", 32'(bus.mispredict_out), 32'd1);
    idle(32'h100, pt);
    chk("lit_beq_predict_after", 32'(pt), 32'd1);
    chk("lit_idle_redirect_hold", bus.redirect_pc_out, 32'h120);

    // Signed vs unsigned less-than
    issue(1'b1, 1'b0, BR, 3'd4, 32'h208, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h208, pt);
    chk("lit_blt_taken", 32'(bus.branch_taken_out), 32'd1);
    issue(1'b1, 1'b0, BR, 3'd6, 32'h208, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h208, pt);
    chk("lit_bltu_taken", 32'(bus.branch_taken_out), 32'd0);
    chk("lit_bltu_redirect", bus.redirect_pc_out, 32'h20C);
    chk("lit_bltu_mispredict", 32'(bus.mispredict_out), 32'd1);
    issue(1'b1, 1'b0, BR, 3'd5, 32'h210, 32'h8, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, pt);
    issue(1'b1, 1'b0, BR, 3'd7, 32'h210, 32'h8, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, pt);
    issue(1'b1, 1'b0, BR, 3'd0, 32'h214, 32'h8, 32'd1, 32'd2, 1'b0, 32'h0, pt);

    // Saturation at 3, then decrement to 2 and 1
    for (int k = 0; k < 4; k++)
      issue(1'b1, 1'b0, BR, 3'd1, 32'h304, 32'h10, 32'd1, 32'd2, 1'b1, 32'h304, pt);
    idle(32'h304, pt);
    chk("lit_bne_sat_predict", 32'(pt), 32'd1);
    issue(1'b1, 1'b0, BR, 3'd1, 32'h304, 32'h10, 32'd7, 32'd7, 1'b1, 32'h304, pt);
    chk("lit_bne_nt_redirect", bus.redirect_pc_out, 32'h308);
    idle(32'h304, pt);
    chk("lit_ctr2_predict", 32'(pt), 32'd1);
    issue(1'b1, 1'b0, BR, 3'd1, 32'h304, 32'h10, 32'd7, 32'd7, 1'b0, 32'h304, pt);
    idle(32'h304, pt);
    chk("lit_ctr1_predict", 32'(pt), 32'd0);

    // Jumps, illegal encoding, wrapped target
    issue(1'b1, 1'b0, JALR, 3'd0, 32'h400, 32'h4, 32'h2001, 32'h0, 1'b0, 32'h400, pt);
    chk("lit_jalr_taken", 32'(bus.branch_taken_out), 32'd1);
    chk("lit_jalr_redirect", bus.redirect_pc_out, 32'h2004);
    chk("lit_jalr_mispredict", 32'(bus.mispredict_out), 32'd1);
    issue(1'b1, 1'b0, JAL, 3'd0, 32'h500, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1, 32'h500, pt);
    chk("lit_jal_redirect", bus.redirect_pc_out, 32'h4F8);
    chk("lit_jal_mispredict", 32'(bus.mispredict_out), 32'd0);
    issue(1'b1, 1'b0, BR, 3'd2, 32'h600, 32'h10, 32'd3, 32'd3, 1'b1, 32'h600, pt);
    chk("lit_illegal", 32'(bus.illegal_out), 32'd1);
    chk("lit_illegal_taken", 32'(bus.branch_taken_out), 32'd0);
    chk("lit_illegal_mispredict", 32'(bus.mispredict_out), 32'd1);
    issue(1'b1, 1'b0, BR, 3'd3, 32'h600, 32'h10, 32'd3, 32'd4, 1'b0, 32'h600, pt);
    issue(1'b1, 1'b0, BR, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9, 1'b1, 32'h0, pt);
    chk("lit_wrap_redirect", bus.redirect_pc_out, 32'h10);

    // Flushed and non-control instructions are dropped
    issue(1'b1, 1'b1, BR, 3'd0, 32'h304, 32'h40, 32'd1, 32'd1, 1'b0, 32'h304, pt);
    chk("lit_flush_resolve", 32'(bus.resolve_valid_out), 32'd0);
    chk("lit_flush_redirect_hold", bus.redirect_pc_out, 32'h10);
    issue(1'b1, 1'b0, 5'b01100, 3'd0, 32'h304, 32'h40, 32'd1, 32'd1, 1'b0, 32'h304, pt);
    chk("lit_other_op_resolve", 32'(bus.resolve_valid_out), 32'd0);
    idle(32'h304, pt);
    chk("lit_flush_no_bht_change", 32'(pt), 32'd0);

    // Back-to-back branches to exercise per-cycle pulse behaviour
    for (int k = 0; k < 6; k++)
      issue(1'b1, 1'b0, BR, 3'(k % 2), 32'h700 + 32'(k * 4), 32'h100,
            32'(k), 32'd2, k[0], 32'h700 + 32'(k * 4), pt);
    idle(32'h700, pt);
    idle(32'h700, pt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
